cdc_mcp_tx_scheduler: RTL



---
 rtl/cdc_mcp_tx_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cdc_mcp_tx_scheduler.sv
// rtl/cdc_mcp_tx_scheduler.sv - round-robin send-side scheduler for a shared MCP CDC channel
module cdc_mcp_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ID_WIDTH       = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk_send,
  input  logic                          rst_send,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          ch_send,
  input  logic                          ch_send_ready,
  input  logic                          ch_ack,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] ch_data,
  output logic                          busy,
  output logic                          timeout_err,
  input  logic                          err_clear
);

  // Counter only needs to reach TIMEOUT_CYCLES; it saturates there.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK
  } state_t;

  state_t                        r_state;
  logic [ID_WIDTH-1:0]           r_rr_ptr;
  logic [ID_WIDTH-1:0]           r_owner;
  logic [ID_WIDTH+DATA_WIDTH-1:0] r_ch_data;
  logic                          r_ch_send;
  logic [NUM_REQ-1:0]            r_req_done;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_timeout_err;

  logic                          w_found;
  logic [ID_WIDTH-1:0]           w_winner;
  logic [ID_WIDTH-1:0]           w_idx;
  logic                          w_grant_en;
  logic [DATA_WIDTH-1:0]         w_payload;
  logic                          w_wd_hit;

  // Round-robin search: first valid requester after the last winner, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_WIDTH'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Grant is combinational in IDLE; suppressed while reset is held so outputs read zero.
  always_comb begin
    w_grant_en = (r_state == S_IDLE) && w_found && ch_send_ready && !rst_send;
    req_grant  = w_grant_en ? (NUM_REQ'(1) << w_winner) : '0;
  end

  assign w_payload = req_data[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];

  // Watchdog fires once, on the edge that brings the counter to the limit.
  assign w_wd_hit = (TIMEOUT_CYCLES > 0) && (r_state == S_WAIT_ACK) && !ch_ack &&
                    (r_cnt == CNT_LAST);

  // Transfer sequencing: capture on grant, strobe send, wait for ack, report done.
  always_ff @(posedge clk_send or posedge rst_send) begin
    if (rst_send) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= ID_WIDTH'(NUM_REQ - 1);
      r_owner    <= '0;
      r_ch_data  <= '0;
      r_ch_send  <= 1'b0;
      r_req_done <= '0;
      r_cnt      <= '0;
    end else begin
      r_ch_send  <= 1'b0;
      r_req_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_en) begin
            r_ch_data <= {w_winner, w_payload};
            r_owner   <= w_winner;
            r_rr_ptr  <= w_winner;
            r_ch_send <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (ch_ack) begin
            r_req_done <= NUM_REQ'(1) << r_owner;
            r_cnt      <= '0;
            r_state    <= S_IDLE;
          end else if ((TIMEOUT_CYCLES > 0) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_send or posedge rst_send) begin
    if (rst_send) begin
      r_timeout_err <= 1'b0;
    end else if (w_wd_hit) begin
      r_timeout_err <= 1'b1;
    end else if (err_clear) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign ch_send     = r_ch_send;
  assign ch_data     = r_ch_data;
  assign req_done    = r_req_done;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;

endmodule
